starfield_ctrl: RTL and testbench

STARFIELD_CTRL -- requirements
Module: starfield_ctrl

---
 rtl/starfield_ctrl.sv | 148 ++++++++++++++
 tb/tb_starfield_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/starfield_ctrl.sv
// Starfield layer controller: detects frame start from the pixel counters,
// holds one pending config and applies it on a frame boundary, and derives
// the vertical scroll offset from the active speed.
module starfield_ctrl #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pxl_x,
  input  logic [10:0] pxl_y,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        cfg_enable,
  input  logic [2:0]  cfg_density,
  input  logic [2:0]  cfg_speed,
  output logic        frame_start,
  output logic        star_en,
  output logic [2:0]  gap_shift,
  output logic [9:0]  y_offset,
  output logic        busy
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned Y_W   = 10;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             capture_c;
  logic             apply_c;
  logic             origin_c;
  logic             origin_q;
  logic             pend_en;
  logic [2:0]       pend_gap;
  logic [2:0]       pend_speed;
  logic [2:0]       speed;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_lim_c;
  logic [Y_W-1:0]   y_nxt;

  // Line width only matters to the pixel generator; kept as a parameter for symmetry.
  logic unused_width;
  assign unused_width = |32'(WIDTH);

  assign origin_c  = (pxl_x == 11'd0) && (pxl_y == 11'd0);
  assign cfg_ready = (state == IDLE);
  assign busy      = (state == PENDING);

  // Rising edge of the (0,0) condition, reported one cycle later; reset
  // preloads origin_q so a counter parked at (0,0) is not a new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      origin_q    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      origin_q    <= origin_c;
      frame_start <= origin_c & ~origin_q;
    end
  end

  // Config handshake state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: accept in IDLE, apply on the next frame boundary in PENDING.
  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    apply_c   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          capture_c = 1'b1;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          apply_c   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-entry pending config buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_en    <= 1'b0;
      pend_gap   <= 3'd0;
      pend_speed <= 3'd0;
    end else if (capture_c) begin
      pend_en    <= cfg_enable;
      pend_gap   <= cfg_density;
      pend_speed <= cfg_speed;
    end
  end

  // Scroll step uses the speed active before this frame; a speed change restarts the divider.
  always_comb begin
    cnt_lim_c = 8'hFF >> (4'(speed) + 4'd1);
    cnt_nxt   = frame_cnt;
    y_nxt     = y_offset;
    if (speed != 3'd0) begin
      if (frame_cnt == cnt_lim_c) begin
        cnt_nxt = '0;
        y_nxt   = (y_offset == Y_W'(HEIGHT - 1)) ? '0 : y_offset + Y_W'(1);
      end else begin
        cnt_nxt = frame_cnt + CNT_W'(1);
      end
    end
    if (apply_c && (pend_speed != speed)) begin
      cnt_nxt = '0;
    end
  end

  // Active settings only move on a frame_start cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      star_en   <= 1'b0;
      gap_shift <= 3'd0;
      speed     <= 3'd0;
      frame_cnt <= '0;
      y_offset  <= '0;
    end else if (frame_start) begin
      frame_cnt <= cnt_nxt;
      y_offset  <= y_nxt;
      if (apply_c) begin
        star_en   <= pend_en;
        gap_shift <= pend_gap;
        speed     <= pend_speed;
      end
    end
  end

endmodule

// File: tb/tb_starfield_ctrl.sv
// Directed bench for starfield_ctrl with a frame-level reference model and
// an expected-output queue checked after each frame_start pulse.
module tb_starfield_ctrl;

  localparam int HEIGHT = 480;

  typedef struct packed {
    logic       en;
    logic [2:0] gap;
    logic [9:0] y;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [10:0] pxl_x;
  logic [10:0] pxl_y;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_enable;
  logic [2:0]  cfg_density;
  logic [2:0]  cfg_speed;
  logic        frame_start;
  logic        star_en;
  logic [2:0]  gap_shift;
  logic [9:0]  y_offset;
  logic        busy;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // reference model state
  int   m_en, m_gap, m_speed, m_cnt, m_y;
  int   m_pv, m_pen, m_pgap, m_pspeed;
  logic fs_d;

  starfield_ctrl #(.WIDTH(640), .HEIGHT(480)) dut (
    .clk(clk),
    .reset(reset),
    .pxl_x(pxl_x),
    .pxl_y(pxl_y),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_enable(cfg_enable),
    .cfg_density(cfg_density),
    .cfg_speed(cfg_speed),
    .frame_start(frame_start),
    .star_en(star_en),
    .gap_shift(gap_shift),
    .y_offset(y_offset),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_en = 0; m_gap = 0; m_speed = 0; m_cnt = 0; m_y = 0;
    m_pv = 0; m_pen = 0; m_pgap = 0; m_pspeed = 0;
  endtask

  // Model of one frame_start cycle, with an optional write presented on it.
  task automatic model_frame(input logic wr, input int en, input int d, input int s);
    int pv;
    int lim;
    pv = m_pv;
    if (m_speed != 0) begin
      lim = (2 ** (7 - m_speed)) - 1;
      if (m_cnt == lim) begin
        m_cnt = 0;
        m_y = (m_y == HEIGHT - 1) ? 0 : m_y + 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (pv != 0) begin
      if (m_pspeed != m_speed) m_cnt = 0;
      m_en = m_pen; m_gap = m_pgap; m_speed = m_pspeed;
      m_pv = 0;
    end
    if (wr && pv == 0) begin
      m_pen = en; m_pgap = d; m_pspeed = s; m_pv = 1;
    end
  endtask

  // Drive one frame boundary; optionally present a write on the frame_start cycle.
  task automatic frame(input logic wr, input int en, input int d, input int s);
    exp_t e;
    pxl_x = 11'd0; pxl_y = 11'd0;
    step();
    chk("frame_start_pulse", 32'(frame_start), 1);
    pxl_x = 11'd5; pxl_y = 11'd3;
    if (wr) begin
      cfg_valid = 1'b1; cfg_enable = en[0]; cfg_density = d[2:0]; cfg_speed = s[2:0];
    end
    model_frame(wr, en, d, s);
    e.en = m_en[0]; e.gap = m_gap[2:0]; e.y = m_y[9:0];
    exp_q.push_back(e);
    step();
    chk("frame_start_one_cycle", 32'(frame_start), 0);
    cfg_valid = 1'b0;
    step();
    step();
  endtask

  // Mid-frame config write with a bounded wait for cfg_ready.
  task automatic write_cfg(input int en, input int d, input int s);
    int n;
    n = 0;
    while (!cfg_ready && n < 20) begin
      step();
      n++;
    end
    chk("cfg_ready_wait", 32'(cfg_ready), 1);
    cfg_valid = 1'b1; cfg_enable = en[0]; cfg_density = d[2:0]; cfg_speed = s[2:0];
    step();
    cfg_valid = 1'b0;
    m_pen = en; m_pgap = d; m_pspeed = s; m_pv = 1;
    chk("cfg_ready_fall", 32'(cfg_ready), 0);
    chk("busy_rise", 32'(busy), 1);
  endtask

  // Present a write while PENDING; it must be refused.
  task automatic hold_blocked(input int en, input int d, input int s, input int n);
    cfg_valid = 1'b1; cfg_enable = en[0]; cfg_density = d[2:0]; cfg_speed = s[2:0];
    for (int i = 0; i < n; i++) begin
      step();
      chk("blocked_ready", 32'(cfg_ready), 0);
      chk("blocked_busy", 32'(busy), 1);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_star_en", 32'(star_en), 0);
    chk("rst_gap_shift", 32'(gap_shift), 0);
    chk("rst_y_offset", 32'(y_offset), 0);
  endtask

  // Scoreboard: compare active outputs one cycle after each frame_start pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      fs_d = 1'b0;
    end else begin
      if (fs_d) begin
        chk("sb_expected_frame", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_star_en", 32'(star_en), 32'(e.en));
          chk("sb_gap_shift", 32'(gap_shift), 32'(e.gap));
          chk("sb_y_offset", 32'(y_offset), 32'(e.y));
        end
      end
      fs_d = frame_start;
    end
  end

  initial begin
    int guard;
    fs_d = 1'b0;
    reset = 1'b1; pxl_x = 11'd0; pxl_y = 11'd0;
    cfg_valid = 1'b0; cfg_enable = 1'b0; cfg_density = 3'd0; cfg_speed = 3'd0;
    model_reset();
    repeat (3) step();
    chk_reset_outputs();

    // Counters parked at (0,0) across reset release: no frame start.
    reset = 1'b0;
    step();
    chk("post_rst_no_fs_1", 32'(frame_start), 0);
    step();
    chk("post_rst_no_fs_2", 32'(frame_start), 0);
    pxl_x = 11'd5; pxl_y = 11'd3;
    step();

    // Config timing: enable, density 3, static.
    write_cfg(1, 3, 0);
    step();
    chk("pending_not_applied", 32'(star_en), 0);
    frame(1'b0, 0, 0, 0);
    chk("cfg_ready_returns", 32'(cfg_ready), 1);
    chk("busy_clears", 32'(busy), 0);

    // Full-speed scroll through the wrap at HEIGHT-1.
    write_cfg(1, 3, 7);
    for (int i = 0; i < 482; i++) frame(1'b0, 0, 0, 0);
    chk("wrapped_y", 32'(y_offset), 32'(m_y));

    // Half-rate scroll, then frozen.
    write_cfg(1, 2, 6);
    for (int i = 0; i < 5; i++) frame(1'b0, 0, 0, 0);
    write_cfg(1, 2, 0);
    for (int i = 0; i < 6; i++) frame(1'b0, 0, 0, 0);

    // Write on the frame_start cycle lands one frame later.
    frame(1'b1, 0, 5, 0);
    chk("coincide_pending", 32'(busy), 1);
    chk("coincide_not_applied", 32'(star_en), 1);
    frame(1'b0, 0, 0, 0);
    chk("coincide_applied", 32'(gap_shift), 5);

    // Back-pressure: second write refused until ready returns.
    write_cfg(1, 4, 0);
    hold_blocked(0, 1, 7, 3);
    frame(1'b0, 0, 0, 0);
    chk("bp_first_applied", 32'(gap_shift), 4);
    write_cfg(0, 1, 7);
    frame(1'b0, 0, 0, 0);
    chk("bp_second_applied", 32'(star_en), 0);

    // Reach y_offset 100 with stars on, leave a config pending, then reset.
    write_cfg(1, 6, 7);
    frame(1'b0, 0, 0, 0);
    guard = 0;
    while (m_y != 100 && guard < 500) begin
      frame(1'b0, 0, 0, 0);
      guard++;
    end
    chk("reach_y100", 32'(y_offset), 100);
    write_cfg(0, 7, 3);
    chk("pre_rst_star_en", 32'(star_en), 1);
    reset = 1'b1;
    step();
    chk_reset_outputs();
    model_reset();
    reset = 1'b0;
    step();
    frame(1'b0, 0, 0, 0);
    chk("rst_discard_star_en", 32'(star_en), 0);
    chk("rst_discard_gap", 32'(gap_shift), 0);
    chk("rst_discard_busy", 32'(busy), 0);
    step();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
